// File: rtl/sort_pipe_pkg.sv
// Shared definitions for the sort_pipe_net bitonic sorting network:
// stage count, per-stage compare-exchange pair table and stage control record.
package sort_pipe_pkg;

  // One compare-exchange: element positions and network direction (1 = reversed)
  typedef struct packed {
    logic [3:0] lo;
    logic [3:0] hi;
    logic       dir;
  } pair_t;

  // Control half of a stage record; data and tags sit alongside in the top
  typedef struct packed {
    logic valid;
    logic desc;
  } stage_ctl_t;

  // Number of compare-exchange stages for an n-element bitonic network
  function automatic int stage_count(input int n);
    int l;
    l = $clog2(n);
    return l * (l + 1) / 2;
  endfunction

  // Pair p of stage s: walks the classic (k, j) bitonic loops to stage s
  function automatic pair_t pair_of(input int n, input int s, input int p);
    pair_t r;
    int    st;
    int    k;
    int    j;
    int    cnt;
    int    l;
    r  = '0;
    st = 0;
    k  = 2;
    while (k <= n) begin
      j = k / 2;
      while (j >= 1) begin
        if (st == s) begin
          cnt = 0;
          for (int i = 0; i < n; i++) begin
            l = i ^ j;
            if (l > i) begin
              if (cnt == p) begin
                r.lo  = 4'(i);
                r.hi  = 4'(l);
                r.dir = ((i & k) != 0);
              end
              cnt++;
            end
          end
        end
        st++;
        j = j / 2;
      end
      k = k * 2;
    end
    return r;
  endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Two-element compare-exchange. y_lo receives the element that belongs first
// under the effective order (network dir XOR transaction desc).
// Optional macro SORT_IDX_EN: tags ride with the values and break ties.
module sort_cmp_swap #(
  parameter int W      = 5,
  parameter bit SIGNED = 1'b0
`ifdef SORT_IDX_EN
  , parameter int IW   = 2
`endif
) (
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
`ifdef SORT_IDX_EN
  input  logic [IW-1:0] a_idx,
  input  logic [IW-1:0] b_idx,
  output logic [IW-1:0] y_lo_idx,
  output logic [IW-1:0] y_hi_idx,
`endif
  input  logic          dir,
  input  logic          desc,
  output logic [W-1:0]  y_lo,
  output logic [W-1:0]  y_hi
);

  logic v_gt;
  logic v_lt;
  logic swap;

  // Magnitude compare in the configured number representation
  always_comb begin
    if (SIGNED) begin
      v_gt = $signed(a) > $signed(b);
      v_lt = $signed(a) < $signed(b);
    end else begin
      v_gt = a > b;
      v_lt = a < b;
    end
  end

`ifdef SORT_IDX_EN
  // a sorts after b in this transaction's base order: value per mode, then lower tag first
  logic after;
  assign after = (desc ? v_lt : v_gt) || (!v_gt && !v_lt && (a_idx > b_idx));
  assign swap  = dir ? !after : after;
  assign y_lo_idx = swap ? b_idx : a_idx;
  assign y_hi_idx = swap ? a_idx : b_idx;
`else
  assign swap = (dir ^ desc) ? v_lt : v_gt;
`endif

  assign y_lo = swap ? b : a;
  assign y_hi = swap ? a : b;

endmodule

// File: rtl/sort_pipe_net.sv
// Fully pipelined bitonic sorter with per-transaction asc/desc and valid/ready.
// Register 0 captures the input; registers 1..S each follow one compare stage.
// Optional macro SORT_IDX_EN: original-position tags and the out_idx port.
module sort_pipe_net
  import sort_pipe_pkg::*;
#(
  parameter int N      = 4,
  parameter int W      = 5,
  parameter bit SIGNED = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_desc,
  input  logic [N*W-1:0]         in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_desc,
  output logic [N*W-1:0]         out_data
`ifdef SORT_IDX_EN
  , output logic [N*$clog2(N)-1:0] out_idx
`endif
);

  localparam int S = stage_count(N);
  localparam int P = N / 2;

  stage_ctl_t                ctl    [S+1];
  logic [N-1:0][W-1:0]       data_q [S+1];
  logic [N-1:0][W-1:0]       data_d [1:S];
  logic                      adv;

`ifdef SORT_IDX_EN
  localparam int L = $clog2(N);
  logic [N-1:0][L-1:0]       idx_q  [S+1];
  logic [N-1:0][L-1:0]       idx_d  [1:S];
  logic [N-1:0][L-1:0]       idx_init;
  for (genvar i = 0; i < N; i++) begin : g_tag
    assign idx_init[i] = L'(i);
  end
`endif

  // The whole pipe moves only when the output slot is empty or being drained
  assign adv      = !ctl[S].valid || out_ready;
  assign in_ready = adv;

  for (genvar s = 1; s <= S; s++) begin : g_stage
    for (genvar p = 0; p < P; p++) begin : g_pair
      localparam pair_t PR  = pair_of(N, s - 1, p);
      localparam int    LO  = int'(PR.lo);
      localparam int    HI  = int'(PR.hi);
      localparam bit    DIR = PR.dir;
      sort_cmp_swap #(
        .W(W),
        .SIGNED(SIGNED)
`ifdef SORT_IDX_EN
        , .IW(L)
`endif
      ) u_cs (
        .a(data_q[s-1][LO]),
        .b(data_q[s-1][HI]),
`ifdef SORT_IDX_EN
        .a_idx(idx_q[s-1][LO]),
        .b_idx(idx_q[s-1][HI]),
        .y_lo_idx(idx_d[s][LO]),
        .y_hi_idx(idx_d[s][HI]),
`endif
        .dir(DIR),
        .desc(ctl[s-1].desc),
        .y_lo(data_d[s][LO]),
        .y_hi(data_d[s][HI])
      );
    end
  end

  // Stage registers: capture at 0, compare results at 1..S, all frozen on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= S; s++) begin
        ctl[s]    <= '0;
        data_q[s] <= '0;
      end
    end else if (adv) begin
      ctl[0].valid <= in_valid;
      ctl[0].desc  <= in_desc;
      data_q[0]    <= in_data;
      for (int s = 1; s <= S; s++) begin
        ctl[s]    <= ctl[s-1];
        data_q[s] <= data_d[s];
      end
    end
  end

`ifdef SORT_IDX_EN
  // Tags shift in lockstep with the data so out_idx always matches out_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= S; s++) idx_q[s] <= '0;
    end else if (adv) begin
      idx_q[0] <= idx_init;
      for (int s = 1; s <= S; s++) idx_q[s] <= idx_d[s];
    end
  end

  assign out_idx = idx_q[S];
`endif

  assign out_valid = ctl[S].valid;
  assign out_desc  = ctl[S].desc;
  assign out_data  = data_q[S];

endmodule

// File: tb/tb_sort_pipe_net.sv
`timescale 1ns/1ps
module tb_sort_pipe_net;

  localparam int S4 = 3;
  localparam int S8 = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid4, in_ready4, in_desc4, out_valid4, out_ready4, out_desc4;
  logic [19:0] in_data4, out_data4;
  logic        in_valid8, in_ready8, in_desc8, out_valid8, out_ready8, out_desc8;
  logic [39:0] in_data8, out_data8;
`ifdef SORT_IDX_EN
  logic [7:0]  out_idx4;
  logic [23:0] out_idx8;
`endif

  sort_pipe_net #(.N(4), .W(5), .SIGNED(1'b0)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_desc(in_desc4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_desc(out_desc4), .out_data(out_data4)
`ifdef SORT_IDX_EN
    , .out_idx(out_idx4)
`endif
  );

  sort_pipe_net #(.N(8), .W(5), .SIGNED(1'b1)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_desc(in_desc8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_desc(out_desc8), .out_data(out_data8)
`ifdef SORT_IDX_EN
    , .out_idx(out_idx8)
`endif
  );

  typedef struct {
    logic        desc;
    logic [19:0] data;
    logic [7:0]  idx;
  } exp_t;

  exp_t        sbq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        stall_prev = 1'b0;
  logic [19:0] data_prev  = '0;
  logic        desc_prev  = 1'b0;

  // Stable insertion sort of the 4x5-bit unsigned vector, tracking positions
  function automatic exp_t ref_sort(input logic [19:0] v, input logic desc);
    int   val[4];
    int   ix[4];
    int   tv, ti, j;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      val[i] = int'(v[i*5 +: 5]);
      ix[i]  = i;
    end
    for (int i = 1; i < 4; i++) begin
      tv = val[i];
      ti = ix[i];
      j  = i;
      while (j > 0) begin
        if (desc ? (val[j-1] < tv) : (val[j-1] > tv)) begin
          val[j] = val[j-1];
          ix[j]  = ix[j-1];
          j--;
        end else break;
      end
      val[j] = tv;
      ix[j]  = ti;
    end
    e.desc = desc;
    e.data = '0;
    e.idx  = '0;
    for (int i = 0; i < 4; i++) begin
      e.data[i*5 +: 5] = 5'(val[i]);
      e.idx[i*2 +: 2]  = 2'(ix[i]);
    end
    return e;
  endfunction

  // One clock of the N=4 DUT: observe at negedge, drive, check handshake and scoreboard
  task automatic cycle4(input logic iv, input logic idesc, input logic [19:0] idata,
                        input logic ordy, output logic ov);
    exp_t e;
    @(negedge clk);
    ov = out_valid4;
    if (stall_prev) begin
      n_tests++;
      if (out_valid4 !== 1'b1 || out_data4 !== data_prev || out_desc4 !== desc_prev) begin
        n_fail++;
        $display("FAIL hold_stable: valid=%b data=%h desc=%b, required valid=1 data=%h desc=%b",
                 out_valid4, out_data4, out_desc4, data_prev, desc_prev);
      end
    end
    in_valid4  = iv;
    in_desc4   = idesc;
    in_data4   = idata;
    out_ready4 = ordy;
    #1;
    n_tests++;
    if (in_ready4 !== (!out_valid4 || ordy)) begin
      n_fail++;
      $display("FAIL in_ready: got %b, required %b (out_valid=%b out_ready=%b)",
               in_ready4, (!out_valid4 || ordy), out_valid4, ordy);
    end
    if (out_valid4 === 1'b1 && ordy) begin
      n_tests++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: data=%h emitted, required no output", out_data4);
      end else begin
        e = sbq.pop_front();
        if (out_data4 !== e.data || out_desc4 !== e.desc) begin
          n_fail++;
          $display("FAIL sort_out: data=%h desc=%b, required data=%h desc=%b",
                   out_data4, out_desc4, e.data, e.desc);
        end
`ifdef SORT_IDX_EN
        n_tests++;
        if (out_idx4 !== e.idx) begin
          n_fail++;
          $display("FAIL sort_idx: got %h, required %h", out_idx4, e.idx);
        end
`endif
      end
    end
    if (iv && in_ready4 === 1'b1) sbq.push_back(ref_sort(idata, idesc));
    stall_prev = (out_valid4 === 1'b1) && !ordy;
    data_prev  = out_data4;
    desc_prev  = out_desc4;
  endtask

  task automatic drain4();
    logic ov;
    for (int i = 0; i < 20 && sbq.size() > 0; i++) cycle4(1'b0, 1'b0, '0, 1'b1, ov);
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, required 0", sbq.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid4 = 1'b0; in_desc4 = 1'b0; in_data4 = '0; out_ready4 = 1'b1;
    in_valid8 = 1'b0; in_desc8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (out_valid4 !== 1'b0 || out_data4 !== '0 || out_desc4 !== 1'b0 || out_valid8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: valid4=%b data4=%h desc4=%b valid8=%b, required all 0",
               out_valid4, out_data4, out_desc4, out_valid8);
    end
`ifdef SORT_IDX_EN
    n_tests++;
    if (out_idx4 !== '0) begin
      n_fail++;
      $display("FAIL reset_idx: got %h, required 0", out_idx4);
    end
`endif
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (in_ready4 !== 1'b1 || in_ready8 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: in_ready4=%b in_ready8=%b, required 1", in_ready4, in_ready8);
    end
  endtask

  task automatic test_basic();
    logic        ov;
    int          nvalid;
    int          first;
    logic [19:0] got;
    nvalid = 0; first = -1; got = '0;
    cycle4(1'b1, 1'b0, {5'd0, 5'd31, 5'd3, 5'd9}, 1'b1, ov);
    for (int i = 1; i <= 6; i++) begin
      cycle4(1'b0, 1'b0, '0, 1'b1, ov);
      if (ov) begin
        nvalid++;
        if (first < 0) begin
          first = i;
          got   = out_data4;
        end
      end
    end
    n_tests++;
    if (nvalid != 1 || first != S4 + 1) begin
      n_fail++;
      $display("FAIL basic_latency: %0d valid cycles first at %0d, required 1 at %0d", nvalid, first, S4 + 1);
    end
    n_tests++;
    if (got !== {5'd31, 5'd9, 5'd3, 5'd0}) begin
      n_fail++;
      $display("FAIL basic_data: got %h, required %h", got, {5'd31, 5'd9, 5'd3, 5'd0});
    end
  endtask

  task automatic test_signed_desc();
    int          vin[8];
    int          vexp[8];
    int          iexp[8];
    logic [39:0] exp_v;
    logic [23:0] exp_i;
    int          cnt;
    vin  = '{-16, 7, 0, -1, 15, 3, -8, 2};
    vexp = '{15, 7, 3, 2, 0, -1, -8, -16};
    iexp = '{4, 1, 5, 7, 2, 3, 6, 0};
    exp_v = '0; exp_i = '0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      in_data8[i*5 +: 5] = 5'(vin[i]);
      exp_v[i*5 +: 5]    = 5'(vexp[i]);
      exp_i[i*3 +: 3]    = 3'(iexp[i]);
    end
    in_desc8 = 1'b1; in_valid8 = 1'b1; out_ready8 = 1'b1;
    cnt = 0;
    while (cnt < 20) begin
      @(negedge clk);
      in_valid8 = 1'b0;
      cnt++;
      if (out_valid8 === 1'b1) break;
    end
    n_tests++;
    if (cnt != S8 + 1) begin
      n_fail++;
      $display("FAIL signed_latency: output at cycle %0d, required %0d", cnt, S8 + 1);
    end
    n_tests++;
    if (out_data8 !== exp_v || out_desc8 !== 1'b1) begin
      n_fail++;
      $display("FAIL signed_desc: data=%h desc=%b, required data=%h desc=1", out_data8, out_desc8, exp_v);
    end
`ifdef SORT_IDX_EN
    n_tests++;
    if (out_idx8 !== exp_i) begin
      n_fail++;
      $display("FAIL signed_idx: got %h, required %h", out_idx8, exp_i);
    end
`endif
    in_desc8 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic ov;
    int   total, run, maxrun;
    total = 0; run = 0; maxrun = 0;
    for (int i = 0; i < 30; i++) begin
      if (i < 20) cycle4(1'b1, 1'(i % 2), 20'($urandom), 1'b1, ov);
      else        cycle4(1'b0, 1'b0, '0, 1'b1, ov);
      if (ov) begin
        total++;
        run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
    end
    n_tests++;
    if (total != 20 || maxrun != 20) begin
      n_fail++;
      $display("FAIL throughput: %0d outputs, longest run %0d, required 20 and 20", total, maxrun);
    end
    drain4();
  endtask

  task automatic test_backpressure();
    logic ov;
    for (int i = 0; i < 12; i++) cycle4(1'b1, 1'(i % 3 == 0), 20'($urandom), !(i >= 4 && i < 9), ov);
    drain4();
  endtask

  task automatic test_reset_midflight();
    logic ov;
    int   nvalid;
    for (int i = 0; i < 3; i++) cycle4(1'b1, 1'b0, 20'($urandom), 1'b1, ov);
    cycle4(1'b0, 1'b0, '0, 1'b0, ov);
    @(negedge clk);
    n_tests++;
    if (out_valid4 !== 1'b1) begin
      n_fail++;
      $display("FAIL midflight_pre: out_valid=%b, required 1", out_valid4);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid4 !== 1'b0 || out_data4 !== '0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b data=%h, required 0 and 0", out_valid4, out_data4);
    end
    sbq.delete();
    stall_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      cycle4(1'b0, 1'b0, '0, 1'b1, ov);
      if (ov) nvalid++;
    end
    n_tests++;
    if (nvalid != 0) begin
      n_fail++;
      $display("FAIL stale_after_reset: %0d outputs, required 0", nvalid);
    end
  endtask

  task automatic test_ties();
    logic        ov;
    logic [19:0] got;
    int          seen;
`ifdef SORT_IDX_EN
    logic [7:0]  goti;
    goti = '0;
`endif
    got = '0; seen = 0;
    cycle4(1'b1, 1'b0, {5'd5, 5'd2, 5'd5, 5'd5}, 1'b1, ov);
    for (int i = 0; i < 8; i++) begin
      cycle4(1'b0, 1'b0, '0, 1'b1, ov);
      if (ov && seen == 0) begin
        seen = 1;
        got  = out_data4;
`ifdef SORT_IDX_EN
        goti = out_idx4;
`endif
      end
    end
    n_tests++;
    if (seen != 1 || got !== {5'd5, 5'd5, 5'd5, 5'd2}) begin
      n_fail++;
      $display("FAIL ties_data: seen=%0d got %h, required %h", seen, got, {5'd5, 5'd5, 5'd5, 5'd2});
    end
`ifdef SORT_IDX_EN
    n_tests++;
    if (goti !== {2'd3, 2'd1, 2'd0, 2'd2}) begin
      n_fail++;
      $display("FAIL ties_idx: got %h, required %h", goti, {2'd3, 2'd1, 2'd0, 2'd2});
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed_desc();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_ties();
    drain4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sort_pipe_net.md
Name: sort_pipe_net

Overview:
- Parametrised, fully pipelined bitonic sorting network. Successor to the team's fixed 4-input, 5-bit sort pipe.
- Generalised in element count, element width and signedness.
- Adds per-transaction ascending/descending select and valid/ready backpressure.
- Sits between the input capture stage and downstream consumers in the lab datapath. Accepts one N-element vector per cycle.

Parameters:
- N, 4, element count; power of two, 4..16.
- W, 5, element width in bits, 1..32.
- SIGNED, 0, 1 = compare as two's complement, 0 = unsigned.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept input this cycle.
- in_desc  in  1  1 = descending (out_data[0] largest), 0 = ascending.
- in_data  in  N*W  element i at bits [i*W +: W].
- out_valid  out  1  output vector valid.
- out_ready  in  1  consumer accepts output.
- out_desc  out  1  in_desc carried with the transaction.
- out_data  out  N*W  sorted vector, same packing as in_data.
- out_idx  out  N*log2(N)  original index of each output element (SORT_IDX_EN only).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all pipeline valids = 0, all data/desc/idx registers = 0. Hence out_valid=0, out_data=0, out_desc=0, out_idx=0. in_ready=1 from the first cycle after deassertion.
- Stage count and latency:
  - L = log2(N); S = L*(L+1)/2 compare-exchange stages. S = 3 for N=4, 6 for N=8, 10 for N=16.
  - Each stage has one register stage carrying valid, desc, data and idx. The last register drives the outputs directly.
  - Latency with out_ready held high: a vector accepted at edge k appears with out_valid=1 after edge k+S.
- Handshake:
  - adv = !out_valid || out_ready; in_ready = adv (combinational).
  - When adv=1, every stage shifts forward by one. Stage 0 loads in_valid, in_desc, in_data. Bubbles propagate as valid=0.
  - When adv=0, all stage registers hold. out_data and out_desc stay stable while out_valid=1 and out_ready=0.
  - in_data is ignored when in_valid=0 or in_ready=0. No transaction is ever dropped or duplicated.
- Comparators:
  - Each compare-exchange orders its pair by the network's fixed bitonic direction XOR the stage's carried desc bit. Different transactions may use different modes back-to-back.
  - SIGNED=1 compares $signed values. Example with W=5: 5'b11111 (-1) is less than 5'b00001.
- Ties: equal values may exchange freely, since the emitted values are identical.
- Full-throughput boundary: back-to-back in_valid with out_ready=1 gives one result per cycle. No bubble is inserted at any stage.
- Simultaneous events:
  - out_ready=0 with in_valid=1 while out_valid=1: input is not accepted (in_ready=0).
  - When the pipe is not full of valids, there is still no compression. A stall freezes the entire pipe, bubbles included.
- Reset mid-operation: all in-flight transactions are discarded immediately. No partial output is produced after release.

Optional Feature:
- Macro: SORT_IDX_EN.
- Defined:
  - Each element carries a log2(N)-bit tag equal to its input position. Tags travel through the swaps, and out_idx reports them.
  - Comparison key becomes {value, idx}, ordered as value per mode, then lower idx first on equal values. Output is therefore deterministic and stable.
- Undefined: no tag registers are built and the out_idx port is absent. Tie order is unspecified.

Decomposition:
- Package sort_pipe_pkg holds:
  - function clog2-based stage count S(N);
  - function returning the (lo, hi, dir) pair table for stage s;
  - typedef for the stage record {valid, desc, data, idx}.
- One sub-module, sort_cmp_swap: parametrised W/SIGNED two-element compare-exchange with dir and desc inputs and optional tag passthrough. It is purely combinational and is instantiated N/2 times per stage from generate loops.

Test Plan:
- Basic case: N=4, W=5, unsigned, asc; in_data elements {9,3,31,0} with out_ready=1. Required: out_data after 3 edges = {0,3,9,31}, out_valid pulses exactly one cycle.
- Mode and signedness: N=8, SIGNED=1, in_desc=1, input {-16,7,0,-1,15,3,-8,2}. Required: {15,7,3,2,0,-1,-8,-16}, out_desc=1.
- Throughput: 20 back-to-back random vectors, mode alternating each cycle, out_ready=1. Required: 20 consecutive out_valid cycles, each matching the reference sort for its own mode.
- Backpressure: hold out_ready=0 for 5 cycles while in_valid=1. Required:
  - in_ready=0 whenever out_valid=1;
  - out_data stable;
  - no loss or duplication after release; scoreboard order preserved.
- Reset mid-flight: assert rst_n=0 with 3 vectors in flight. Required: out_valid=0 asynchronously, and no stale vector emitted after release.
- Ties (SORT_IDX_EN): N=4, input {5,5,2,5}, asc. Required: out_data {2,5,5,5}, out_idx {2,0,1,3}.
